// File: rtl/bcd_pkg.sv
// Shared BCD digit limits, terminal-mode constants and a digit-validity helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Terminal behaviour selectors for the counter's WRAP parameter.
    localparam int WRAP_SATURATE = 0;
    localparam int WRAP_ROLLOVER = 1;

    // A nibble is a legal BCD digit only in 0..9.
    function automatic logic digit_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit slice: next-digit value and ripple-out for an up/down step.
// Latency: combinational.
// Backpressure: none; a step is taken whenever step is high.
// Ports: cur (present digit), step (advance this digit), up (direction),
//        nxt (digit after the step), ripple (this digit rolled over, so the next digit steps).
module bcd_digit (
    input  logic [3:0] cur,
    input  logic       step,
    input  logic       up,
    output logic [3:0] nxt,
    output logic       ripple
);
    import bcd_pkg::*;

    always_comb begin
        nxt    = cur;
        ripple = 1'b0;
        if (step) begin
            if (up) begin
                if (cur == BCD_MAX) begin
                    nxt    = BCD_MIN;
                    ripple = 1'b1;
                end else begin
                    nxt = cur + 4'd1;
                end
            end else begin
                if (cur == BCD_MIN) begin
                    nxt    = BCD_MAX;
                    ripple = 1'b1;
                end else begin
                    nxt = cur - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded DIGITS-wide BCD up/down counter with clear, validated load and wrap/saturate terminal mode.
// Latency: o_Q, o_Carry, o_LdErr registered (1 edge); o_TC combinational from o_Q and i_Up.
// Backpressure: none; i_Clr > i_Load > i_En > hold is resolved on every rising edge.
// Ports: i_Clk, i_GRst_n (async active-low), i_Clr, i_Load, i_D (load value, digit 0 in [3:0]),
//        i_En, i_Up, o_Q (count), o_Carry (terminal-event pulse), o_TC (terminal flag), o_LdErr (rejected load pulse).
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_GRst_n,
    input  logic                  i_Clr,
    input  logic                  i_Load,
    input  logic [4*DIGITS-1:0]   i_D,
    input  logic                  i_En,
    input  logic                  i_Up,
    output logic [4*DIGITS-1:0]   o_Q,
    output logic                  o_Carry,
    output logic                  o_TC,
    output logic                  o_LdErr
);
    import bcd_pkg::*;

    logic [4*DIGITS-1:0] q_next;
    // step[k] advances digit k; step[DIGITS] set means the whole counter crossed its end.
    logic [DIGITS:0]     step;
    logic [DIGITS-1:0]   at_end;
    logic                d_ok;
    logic                terminal;

    assign step[0] = i_En;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .cur    (o_Q[4*k +: 4]),
            .step   (step[k]),
            .up     (i_Up),
            .nxt    (q_next[4*k +: 4]),
            .ripple (step[k+1])
        );
        assign at_end[k] = i_Up ? (o_Q[4*k +: 4] == BCD_MAX) : (o_Q[4*k +: 4] == BCD_MIN);
    end

    assign o_TC     = &at_end;
    assign terminal = step[DIGITS];

    always_comb begin
        d_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_valid(i_D[4*k +: 4])) begin
                d_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_GRst_n) begin
        if (!i_GRst_n) begin
            o_Q     <= '0;
            o_Carry <= 1'b0;
            o_LdErr <= 1'b0;
        end else if (i_Clr) begin
            o_Q     <= '0;
            o_Carry <= 1'b0;
            o_LdErr <= 1'b0;
        end else if (i_Load) begin
            // A load with any non-BCD digit is dropped; the count is kept intact.
            if (d_ok) begin
                o_Q <= i_D;
            end
            o_LdErr <= !d_ok;
            o_Carry <= 1'b0;
        end else if (i_En) begin
            // In saturate mode the terminal edge still reports, but the count stays put.
            if (!(terminal && (WRAP == WRAP_SATURATE))) begin
                o_Q <= q_next;
            end
            o_Carry <= terminal;
            o_LdErr <= 1'b0;
        end else begin
            o_Carry <= 1'b0;
            o_LdErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (2-digit wrap, 2-digit saturate, 4-digit wrap)
// share one stimulus; an integer-arithmetic model is checked every cycle, plus literal spot checks.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, load, en, up;
    logic [15:0] d;
    logic [7:0]  qa, qb;
    logic [15:0] qc;
    logic [2:0]  carry, tc, lderr;
    bit          chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
        .i_Clk(clk), .i_GRst_n(rst_n), .i_Clr(clr), .i_Load(load), .i_D(d[7:0]),
        .i_En(en), .i_Up(up), .o_Q(qa), .o_Carry(carry[0]), .o_TC(tc[0]), .o_LdErr(lderr[0]));

    bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_sat (
        .i_Clk(clk), .i_GRst_n(rst_n), .i_Clr(clr), .i_Load(load), .i_D(d[7:0]),
        .i_En(en), .i_Up(up), .o_Q(qb), .o_Carry(carry[1]), .o_TC(tc[1]), .o_LdErr(lderr[1]));

    bcd_updown_counter #(.DIGITS(4), .WRAP(1)) u_wide (
        .i_Clk(clk), .i_GRst_n(rst_n), .i_Clr(clr), .i_Load(load), .i_D(d),
        .i_En(en), .i_Up(up), .o_Q(qc), .o_Carry(carry[2]), .o_TC(tc[2]), .o_LdErr(lderr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (plain integers) ----------------
    function automatic int ndig(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic bit wraps(input int i);
        return (i != 1);
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [15:0] v, input int n);
        int r = 0;
        for (int k = n - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int x, input int n);
        logic [15:0] r = '0;
        int          y = x;
        for (int k = 0; k < n; k++) begin
            r[4*k +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    int mv[3];
    bit mc[3];
    bit me[3];

    always @(posedge clk or negedge rst_n) begin
        int mx;
        for (int i = 0; i < 3; i++) begin
            mx = pow10(ndig(i)) - 1;
            if (!rst_n || clr) begin
                mv[i] = 0; mc[i] = 0; me[i] = 0;
            end else if (load) begin
                if (bcd_ok(d, ndig(i))) begin
                    mv[i] = from_bcd(d, ndig(i)); me[i] = 0;
                end else begin
                    me[i] = 1;
                end
                mc[i] = 0;
            end else if (en) begin
                me[i] = 0;
                if (up) begin
                    mc[i] = (mv[i] == mx);
                    mv[i] = (mv[i] < mx) ? mv[i] + 1 : (wraps(i) ? 0 : mv[i]);
                end else begin
                    mc[i] = (mv[i] == 0);
                    mv[i] = (mv[i] > 0) ? mv[i] - 1 : (wraps(i) ? mx : mv[i]);
                end
            end else begin
                mc[i] = 0; me[i] = 0;
            end
        end
    end

    // One compare process, mid-cycle.
    always @(negedge clk) begin
        logic [31:0] dq;
        bit          etc;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                dq  = (i == 0) ? {24'h0, qa} : (i == 1) ? {24'h0, qb} : {16'h0, qc};
                etc = up ? (mv[i] == pow10(ndig(i)) - 1) : (mv[i] == 0);
                check($sformatf("model_q[%0d]", i), dq, {16'h0, to_bcd(mv[i], ndig(i))});
                check($sformatf("model_carry[%0d]", i), {31'h0, carry[i]}, {31'h0, mc[i]});
                check($sformatf("model_lderr[%0d]", i), {31'h0, lderr[i]}, {31'h0, me[i]});
                check($sformatf("model_tc[%0d]", i), {31'h0, tc[i]}, {31'h0, etc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = 16'h0;
        tick(); tick();
        chk_en = 1'b1;
        check("reset_q", {24'h0, qa}, 32'h0);
        check("reset_carry", {29'h0, carry}, 32'h0);
        check("reset_lderr", {29'h0, lderr}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_release_q", {16'h0, qc}, 32'h0);

        // Wrap from 99 to 00 with a carry only on the wrapping edge; saturate copy holds at 99.
        load = 1'b1; d = 16'h0098; tick();
        check("load_98", {24'h0, qa}, 32'h98);
        load = 1'b0; en = 1'b1; up = 1'b1; tick();
        check("up_99_q", {24'h0, qa}, 32'h99);
        check("up_99_carry", {31'h0, carry[0]}, 32'h0);
        tick();
        check("wrap_00_q", {24'h0, qa}, 32'h00);
        check("wrap_00_carry", {31'h0, carry[0]}, 32'h1);
        check("sat_99_q", {24'h0, qb}, 32'h99);
        check("sat_99_carry", {31'h0, carry[1]}, 32'h1);

        // Saturating underflow: stays at 00, carry every enabled edge, TC held.
        en = 1'b0; clr = 1'b1; tick();
        clr = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        check("sat_tc_pre", {31'h0, tc[1]}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_under_q", {24'h0, qb}, 32'h00);
            check("sat_under_carry", {31'h0, carry[1]}, 32'h1);
            check("sat_under_tc", {31'h0, tc[1]}, 32'h1);
        end
        check("wrap_down_97", {24'h0, qa}, 32'h97);

        // Rejected load keeps the count and pulses LdErr once; a valid load follows.
        en = 1'b0; load = 1'b1; d = 16'h003A; tick();
        check("bad_load_q", {24'h0, qa}, 32'h97);
        check("bad_load_err", {31'h0, lderr[0]}, 32'h1);
        d = 16'h0039; tick();
        check("good_load_q", {24'h0, qa}, 32'h39);
        check("good_load_err", {31'h0, lderr[0]}, 32'h0);
        load = 1'b0; tick();
        check("err_cleared", {31'h0, lderr[0]}, 32'h0);

        // Clear beats load and enable on the same edge, no pulses.
        load = 1'b1; d = 16'h0055; tick();
        check("load_55", {24'h0, qa}, 32'h55);
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b0; tick();
        check("clr_prio_q", {24'h0, qa}, 32'h00);
        check("clr_prio_carry", {29'h0, carry}, 32'h0);
        check("clr_prio_lderr", {29'h0, lderr}, 32'h0);

        // Direction change applies on the very next enabled edge.
        clr = 1'b0; en = 1'b0; load = 1'b1; d = 16'h0010; tick();
        load = 1'b0; en = 1'b1; up = 1'b0; tick();
        check("down_09", {24'h0, qa}, 32'h09);
        up = 1'b1; tick();
        check("up_10", {24'h0, qa}, 32'h10);

        // Hold with enable low.
        en = 1'b0; tick(); tick(); tick();
        check("hold_10", {24'h0, qa}, 32'h10);

        // Long sweeps, checked by the model every cycle.
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 95; k++) tick();
        check("sweep_wrap_05", {24'h0, qa}, 32'h05);
        check("sweep_sat_99", {24'h0, qb}, 32'h99);
        for (int k = 0; k < 30; k++) begin
            up = ((k / 5) % 2) == 1;
            tick();
        end

        // Asynchronous reset mid-count on the 4-digit instance.
        en = 1'b0; load = 1'b1; d = 16'h1234; tick();
        load = 1'b0; en = 1'b1; up = 1'b1; tick();
        check("wide_1235", {16'h0, qc}, 32'h1235);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_q", {16'h0, qc}, 32'h0);
        check("async_rst_carry", {29'h0, carry}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("resume_0001", {16'h0, qc}, 32'h0001);
        tick();
        check("resume_0002", {16'h0, qc}, 32'h0002);

        en = 1'b0; tick(); tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
